// File: rtl/vga_pkg.sv
// Shared VGA timing constants (640x480@60) and the lock FSM encoding,
// common to the capture side and the output driver.
package vga_pkg;

    localparam int H_ACT_START = 144;
    localparam int H_DISP      = 640;
    localparam int H_TOTAL     = 800;
    localparam int V_ACT_START = 35;
    localparam int V_DISP      = 480;
    localparam int V_TOTAL     = 525;

    localparam int                IDX_W   = 10;
    localparam logic [IDX_W-1:0]  IDX_MAX = '1;

    typedef enum logic [1:0] {
        UNLOCK = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } lock_state_e;

    // Line/frame counters stick at all-ones so a stalled sync never wraps.
    function automatic logic [IDX_W-1:0] sat_inc(input logic [IDX_W-1:0] v);
        return (v == IDX_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Registers one sync input, keeps the previous sample and flags its rising edge.
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic sig_q, sig_d;
    logic hist_q, hist_d;

    always_comb begin
        sig_d  = din;
        hist_d = sig_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q  <= 1'b0;
            hist_q <= 1'b0;
        end else begin
            sig_q  <= sig_d;
            hist_q <= hist_d;
        end
    end

    assign rise = sig_q & ~hist_q;

endmodule

// File: rtl/vga_capture.sv
// VGA sink: recovers h/v position from sync edges, verifies line/frame lengths,
// and emits active-pixel coordinates two clocks after the input pins.
module vga_capture #(
    parameter int H_ACT_START = vga_pkg::H_ACT_START,
    parameter int H_DISP      = vga_pkg::H_DISP,
    parameter int H_TOTAL     = vga_pkg::H_TOTAL,
    parameter int V_ACT_START = vga_pkg::V_ACT_START,
    parameter int V_DISP      = vga_pkg::V_DISP,
    parameter int V_TOTAL     = vga_pkg::V_TOTAL
) (
    input  logic       clk_vga,
    input  logic       rst,
    input  logic       vga_hs,
    input  logic       vga_vs,
    input  logic [2:0] vga_rgb,
    output logic       pix_valid,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic [2:0] pix_rgb,
    output logic       frame_start,
    output logic       locked,
    output logic       err_line,
    output logic       err_frame
);

    import vga_pkg::*;

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_END  = 10'(H_TOTAL);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_END  = 10'(V_TOTAL);
    localparam logic [9:0] HA_LO  = 10'(H_ACT_START);
    localparam logic [9:0] HA_HI  = 10'(H_ACT_START + H_DISP);
    localparam logic [9:0] VA_LO  = 10'(V_ACT_START);
    localparam logic [9:0] VA_HI  = 10'(V_ACT_START + V_DISP);

    logic hs_rise, vs_rise;

    sync_edge_det u_hs_det (.clk(clk_vga), .rst(rst), .din(vga_hs), .rise(hs_rise));
    sync_edge_det u_vs_det (.clk(clk_vga), .rst(rst), .din(vga_vs), .rise(vs_rise));

    logic [2:0]  rgb_q, rgb_d;
    logic [9:0]  h_idx_q, h_idx_d;
    logic [9:0]  v_idx_q, v_idx_d;
    lock_state_e state_q, state_d;
    logic        chk_en, err_line_now, err_frame_now;

    logic       pix_valid_q, pix_valid_d;
    logic [9:0] pix_x_q, pix_x_d;
    logic [9:0] pix_y_q, pix_y_d;
    logic [2:0] pix_rgb_q, pix_rgb_d;
    logic       frame_start_q, frame_start_d;
    logic       err_line_q, err_line_d;
    logic       err_frame_q, err_frame_d;

    // h_idx_d/v_idx_d are the position of the sample currently in rgb_q;
    // the _q copies are the previous sample's position used by the checks.
    always_comb begin
        rgb_d   = vga_rgb;
        h_idx_d = hs_rise ? 10'd0 : sat_inc(h_idx_q);
        if (vs_rise)
            v_idx_d = 10'd0;
        else if (hs_rise)
            v_idx_d = sat_inc(v_idx_q);
        else
            v_idx_d = v_idx_q;
    end

    // Timeouts fire only on the transition into H_END/V_END, so a saturated
    // counter cannot produce a second pulse.
    always_comb begin
        chk_en        = (state_q != UNLOCK);
        err_line_now  = chk_en && (hs_rise ? (h_idx_q != H_LAST) : (h_idx_d == H_END));
        err_frame_now = chk_en && (vs_rise ? (v_idx_q != V_LAST)
                                           : (hs_rise && (v_idx_d == V_END)));
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            UNLOCK: if (vs_rise) state_d = TRACK;
            TRACK: begin
                if (err_line_now || err_frame_now)
                    state_d = UNLOCK;
                else if (vs_rise)
                    state_d = LOCKED;
            end
            LOCKED: if (err_line_now || err_frame_now) state_d = UNLOCK;
            default: state_d = UNLOCK;
        endcase
    end

    always_comb begin
        pix_valid_d   = (state_q == LOCKED)
                      && (h_idx_d >= HA_LO) && (h_idx_d < HA_HI)
                      && (v_idx_d >= VA_LO) && (v_idx_d < VA_HI);
        pix_x_d       = pix_valid_d ? (h_idx_d - HA_LO) : 10'd0;
        pix_y_d       = pix_valid_d ? (v_idx_d - VA_LO) : 10'd0;
        pix_rgb_d     = pix_valid_d ? rgb_q : 3'd0;
        frame_start_d = vs_rise;
        err_line_d    = err_line_now;
        err_frame_d   = err_frame_now;
    end

    always_ff @(posedge clk_vga) begin
        if (rst) begin
            rgb_q         <= 3'd0;
            h_idx_q       <= IDX_MAX;
            v_idx_q       <= IDX_MAX;
            state_q       <= UNLOCK;
            pix_valid_q   <= 1'b0;
            pix_x_q       <= 10'd0;
            pix_y_q       <= 10'd0;
            pix_rgb_q     <= 3'd0;
            frame_start_q <= 1'b0;
            err_line_q    <= 1'b0;
            err_frame_q   <= 1'b0;
        end else begin
            rgb_q         <= rgb_d;
            h_idx_q       <= h_idx_d;
            v_idx_q       <= v_idx_d;
            state_q       <= state_d;
            pix_valid_q   <= pix_valid_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            pix_rgb_q     <= pix_rgb_d;
            frame_start_q <= frame_start_d;
            err_line_q    <= err_line_d;
            err_frame_q   <= err_frame_d;
        end
    end

    assign pix_valid   = pix_valid_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign pix_rgb     = pix_rgb_q;
    assign frame_start = frame_start_q;
    assign locked      = (state_q == LOCKED);
    assign err_line    = err_line_q;
    assign err_frame   = err_frame_q;

endmodule

// File: tb/tb_vga_capture.sv
// Scoreboarded bench for vga_capture on a scaled-down raster (40x20 clocks).
`timescale 1ns/1ps
module tb_vga_capture;

    localparam int HT = 40, HA = 8, HD = 24;
    localparam int VT = 20, VA = 3, VD = 14;
    localparam int HS_W = 5, STALL = 1200;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       vga_hs = 1'b0, vga_vs = 1'b0;
    logic [2:0] vga_rgb = 3'd0;
    logic       pix_valid, frame_start, locked, err_line, err_frame;
    logic [9:0] pix_x, pix_y;
    logic [2:0] pix_rgb;

    vga_capture #(
        .H_ACT_START(HA), .H_DISP(HD), .H_TOTAL(HT),
        .V_ACT_START(VA), .V_DISP(VD), .V_TOTAL(VT)
    ) dut (
        .clk_vga(clk), .rst(rst), .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_rgb(vga_rgb),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
        .frame_start(frame_start), .locked(locked),
        .err_line(err_line), .err_frame(err_frame)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         x;
        int         y;
        logic [2:0] rgb;
        int         cyc;
    } pix_t;

    pix_t exp_q[$];
    int   fs_q[$], el_q[$], ef_q[$];
    int   vectors = 0, miscompares = 0, cyc = 0;
    int   pv_cnt = 0, lock_rise_cyc = -1, first_pv_cyc = -1;
    int   first_x = -1, first_y = -1, last_x = -1, last_y = -1;
    bit   want_first = 0, locked_prev = 0, el_prev = 0, ef_prev = 0;
    bit   locked_after_el = 1, locked_after_ef = 1;
    bit   exp_en = 0;
    int   frame_stamp = 0, rst_line = -1;

    // One clock: observe outputs #1 after the edge, then log events.
    task automatic tick();
        pix_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            vectors++;
            if ({pix_valid, pix_x, pix_y, pix_rgb, frame_start, locked, err_line, err_frame} !== 27'd0) begin
                miscompares++;
                $display("FAIL reset_zero cyc=%0d got pv=%b x=%0d y=%0d rgb=%0d fs=%b lk=%b el=%b ef=%b, required all 0",
                         cyc, pix_valid, pix_x, pix_y, pix_rgb, frame_start, locked, err_line, err_frame);
            end
        end
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL missing_pixel cyc=%0d got no pixel, required x=%0d y=%0d", e.cyc, e.x, e.y);
        end
        if (pix_valid === 1'b1) begin
            pv_cnt++;
            last_x = int'(pix_x);
            last_y = int'(pix_y);
            if (want_first) begin
                first_pv_cyc = cyc; first_x = int'(pix_x); first_y = int'(pix_y); want_first = 0;
            end
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_pixel cyc=%0d got x=%0d y=%0d, required no pixel", cyc, pix_x, pix_y);
            end else begin
                e = exp_q.pop_front();
                if (pix_x !== 10'(e.x) || pix_y !== 10'(e.y) || pix_rgb !== e.rgb || cyc != e.cyc) begin
                    miscompares++;
                    $display("FAIL pixel cyc=%0d got (%0d,%0d,rgb %0d), required (%0d,%0d,rgb %0d) at cyc %0d",
                             cyc, pix_x, pix_y, pix_rgb, e.x, e.y, e.rgb, e.cyc);
                end
            end
        end else begin
            vectors++;
            if ({pix_x, pix_y, pix_rgb} !== 23'd0) begin
                miscompares++;
                $display("FAIL idle_zero cyc=%0d got x=%0d y=%0d rgb=%0d, required 0", cyc, pix_x, pix_y, pix_rgb);
            end
        end
        if (frame_start === 1'b1) begin fs_q.push_back(cyc); want_first = 1; end
        if (err_line === 1'b1) el_q.push_back(cyc);
        if (err_frame === 1'b1) ef_q.push_back(cyc);
        if (el_prev) locked_after_el = locked;
        if (ef_prev) locked_after_ef = locked;
        if (locked === 1'b1 && !locked_prev) lock_rise_cyc = cyc;
        el_prev     = (err_line === 1'b1);
        ef_prev     = (err_frame === 1'b1);
        locked_prev = (locked === 1'b1);
    endtask

    task automatic drive_line(input int len, input bit hs_en, input bit vs_lvl, input int line_no);
        for (int s = 0; s < len; s++) begin
            tick();
            if (line_no == rst_line && s == 0) begin
                rst = 1'b1; exp_en = 0;
            end else if (line_no == rst_line && s == 10) begin
                rst = 1'b0; rst_line = -1;
            end
            vga_hs  = hs_en && (s < HS_W);
            vga_vs  = vs_lvl;
            vga_rgb = 3'($urandom_range(0, 7));
            if (exp_en && s >= HA && s < HA + HD && line_no >= VA && line_no < VA + VD)
                exp_q.push_back('{x: s - HA, y: line_no - VA, rgb: vga_rgb, cyc: cyc + 2});
        end
    endtask

    task automatic drive_frame(input bit expv, input bit vs_en, input int short_ln, input int stall_ln);
        int len;
        exp_en      = expv;
        frame_stamp = cyc + 1;
        for (int l = 0; l < VT; l++) begin
            len = (l == short_ln) ? HT - 1 : (l == stall_ln) ? STALL : HT;
            drive_line(len, l != stall_ln, vs_en && (l == 0), l);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        vectors++;
        if (locked !== 1'b0 || pix_valid !== 1'b0 || frame_start !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state got lk=%b pv=%b fs=%b, required 0 0 0", locked, pix_valid, frame_start);
        end
        rst = 1'b0;
    endtask

    task automatic test_nominal();
        int b = fs_q.size(), el0 = el_q.size(), ef0 = ef_q.size(), pv0;
        drive_frame(0, 1, -1, -1);
        drive_frame(1, 1, -1, -1);
        pv0 = pv_cnt;
        drive_frame(1, 1, -1, -1);
        vectors++;
        if (fs_q.size() - b != 3) begin
            miscompares++;
            $display("FAIL nom_fs_count got %0d, required 3", fs_q.size() - b);
        end else begin
            vectors++;
            if (lock_rise_cyc != fs_q[b+1]) begin
                miscompares++;
                $display("FAIL nom_lock_time got %0d, required %0d", lock_rise_cyc, fs_q[b+1]);
            end
        end
        vectors++;
        if (pv_cnt - pv0 != HD * VD) begin
            miscompares++;
            $display("FAIL nom_pv_count got %0d, required %0d", pv_cnt - pv0, HD * VD);
        end
        vectors++;
        if (first_pv_cyc != frame_stamp + 2 + VA * HT + HA || first_x != 0 || first_y != 0) begin
            miscompares++;
            $display("FAIL nom_first_pixel got cyc %0d (%0d,%0d), required cyc %0d (0,0)",
                     first_pv_cyc, first_x, first_y, frame_stamp + 2 + VA * HT + HA);
        end
        vectors++;
        if (last_x != HD - 1 || last_y != VD - 1) begin
            miscompares++;
            $display("FAIL nom_last_pixel got (%0d,%0d), required (%0d,%0d)", last_x, last_y, HD - 1, VD - 1);
        end
        vectors++;
        if (el_q.size() != el0 || ef_q.size() != ef0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL nom_clean got el %0d ef %0d pending %0d, required 0 0 0",
                     el_q.size() - el0, ef_q.size() - ef0, exp_q.size());
        end
    endtask

    task automatic test_coincident();
        int b = fs_q.size(), el0 = el_q.size(), ef0 = ef_q.size();
        drive_frame(1, 1, -1, -1);
        vectors++;
        if (fs_q.size() - b != 1 || el_q.size() != el0 || ef_q.size() != ef0) begin
            miscompares++;
            $display("FAIL coinc_events got fs %0d el %0d ef %0d, required 1 0 0",
                     fs_q.size() - b, el_q.size() - el0, ef_q.size() - ef0);
        end
        vectors++;
        if (first_y != 0 || locked_prev != 1'b1) begin
            miscompares++;
            $display("FAIL coinc_vidx got first_y %0d locked %0b, required 0 1", first_y, locked_prev);
        end
    endtask

    task automatic test_short_line();
        int el0 = el_q.size(), ef0 = ef_q.size(), exp_cyc;
        drive_frame(0, 1, 1, -1);
        exp_cyc = frame_stamp + 2 * HT - 1 + 2;
        vectors++;
        if (el_q.size() - el0 != 1) begin
            miscompares++;
            $display("FAIL short_el_count got %0d, required 1", el_q.size() - el0);
        end else begin
            vectors++;
            if (el_q[el0] != exp_cyc || locked_after_el != 1'b0) begin
                miscompares++;
                $display("FAIL short_el_time got cyc %0d locked_after %0b, required cyc %0d locked_after 0",
                         el_q[el0], locked_after_el, exp_cyc);
            end
        end
        drive_frame(0, 1, -1, -1);
        drive_frame(1, 1, -1, -1);
        vectors++;
        if (locked_prev != 1'b1 || el_q.size() - el0 != 1 || ef_q.size() != ef0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL short_relock got locked %0b el %0d ef %0d pending %0d, required 1 1 0 0",
                     locked_prev, el_q.size() - el0, ef_q.size() - ef0, exp_q.size());
        end
    endtask

    task automatic test_missing_vsync();
        int el0 = el_q.size(), ef0 = ef_q.size();
        drive_frame(0, 0, -1, -1);
        vectors++;
        if (ef_q.size() - ef0 != 1) begin
            miscompares++;
            $display("FAIL novs_ef_count got %0d, required 1", ef_q.size() - ef0);
        end else begin
            vectors++;
            if (ef_q[ef0] != frame_stamp + 2 || locked_after_ef != 1'b0) begin
                miscompares++;
                $display("FAIL novs_ef_time got cyc %0d locked_after %0b, required cyc %0d locked_after 0",
                         ef_q[ef0], locked_after_ef, frame_stamp + 2);
            end
        end
        drive_frame(0, 1, -1, -1);
        drive_frame(1, 1, -1, -1);
        vectors++;
        if (locked_prev != 1'b1 || ef_q.size() - ef0 != 1 || el_q.size() != el0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL novs_relock got locked %0b ef %0d el %0d pending %0d, required 1 1 0 0",
                     locked_prev, ef_q.size() - ef0, el_q.size() - el0, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int b;
        rst_line = 10;
        drive_frame(1, 1, -1, -1);
        b = fs_q.size();
        drive_frame(0, 1, -1, -1);
        drive_frame(1, 1, -1, -1);
        vectors++;
        if (fs_q.size() - b != 2) begin
            miscompares++;
            $display("FAIL rstmid_fs_count got %0d, required 2", fs_q.size() - b);
        end else begin
            vectors++;
            if (lock_rise_cyc != fs_q[b+1]) begin
                miscompares++;
                $display("FAIL rstmid_lock_time got %0d, required %0d", lock_rise_cyc, fs_q[b+1]);
            end
        end
        vectors++;
        if (locked_prev != 1'b1 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL rstmid_relock got locked %0b pending %0d, required 1 0", locked_prev, exp_q.size());
        end
    endtask

    task automatic test_stall();
        int el0 = el_q.size(), ef0 = ef_q.size();
        drive_frame(0, 1, -1, 1);
        vectors++;
        if (el_q.size() - el0 != 1) begin
            miscompares++;
            $display("FAIL stall_el_count got %0d, required 1", el_q.size() - el0);
        end else begin
            vectors++;
            if (el_q[el0] != frame_stamp + HT + 2) begin
                miscompares++;
                $display("FAIL stall_el_time got cyc %0d, required cyc %0d", el_q[el0], frame_stamp + HT + 2);
            end
        end
        drive_frame(0, 1, -1, -1);
        drive_frame(1, 1, -1, -1);
        vectors++;
        if (locked_prev != 1'b1 || el_q.size() - el0 != 1 || ef_q.size() != ef0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL stall_relock got locked %0b el %0d ef %0d pending %0d, required 1 1 0 0",
                     locked_prev, el_q.size() - el0, ef_q.size() - ef0, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_coincident();
        test_short_line();
        test_missing_vsync();
        test_reset_mid();
        test_stall();
        for (int i = 0; i < 4; i++) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vga_capture.md
# vga_capture

Sink-side VGA timing recovery for the 640x480@60 link. Samples incoming `vga_hs`/`vga_vs`/`vga_rgb` in the pixel-clock domain, locks to the sync structure, and emits per-pixel coordinates with a valid strobe. A downstream frame-buffer writer or checker consumes it, and it is the loopback checker for the on-board VGA output path. It also flags line-length and frame-length violations.

## Interface
Parameters:
- `H_ACT_START` — 144 — sample index within a line of the first active pixel (sync + back porch)
- `H_DISP` — 640 — active pixels per line
- `H_TOTAL` — 800 — clocks per line
- `V_ACT_START` — 35 — line index of the first active line
- `V_DISP` — 480 — active lines per frame
- `V_TOTAL` — 525 — lines per frame

Ports (one clock; reset is synchronous and active-high):
- `clk_vga` in 1 — pixel clock
- `rst` in 1 — synchronous, active-high reset
- `vga_hs` in 1 — horizontal sync, active high
- `vga_vs` in 1 — vertical sync, active high
- `vga_rgb` in 3 — pixel colour
- `pix_valid` out 1 — active pixel present on `pix_x`/`pix_y`/`pix_rgb`
- `pix_x` out 10 — active column 0..639
- `pix_y` out 10 — active row 0..479
- `pix_rgb` out 3 — captured colour
- `frame_start` out 1 — one-cycle pulse on every detected vs rising edge
- `locked` out 1 — timing verified and stable
- `err_line` out 1 — one-cycle pulse on a line-length violation
- `err_frame` out 1 — one-cycle pulse on a frame-length violation

## Operation
- **Stage 1: input registration.**
  - All three inputs are registered once (`hs_q`, `vs_q`, `rgb_q`); `hs_qq`/`vs_qq` hold the previous samples.
  - `hs_rise = hs_q & ~hs_qq`; `vs_rise` is formed the same way.
- **Stage 1: horizontal index (10 bits).**
  - `h_idx` is 0 on the sample where `hs_rise` is seen; otherwise it is the previous value + 1.
  - It saturates at 1023.
- **Stage 1: vertical index (10 bits).**
  - On `vs_rise`, `v_idx` is set to 0; vs_rise takes priority when it coincides with `hs_rise`, which is the normal case.
  - On `hs_rise` alone, `v_idx` increments, saturating at 1023.
- **Lock FSM** (state encoding in the package):
  - `UNLOCK`: on `vs_rise` -> `TRACK`.
  - `TRACK`:
    - On `err_line` or `err_frame` -> `UNLOCK`.
    - On the next `vs_rise` with no error during the frame -> `LOCKED`.
  - `LOCKED`: on `err_line` or `err_frame` -> `UNLOCK`.
  - `locked` is 1 only in `LOCKED`.
- **Checks, evaluated only in `TRACK`/`LOCKED`:**
  - `err_line`:
    - Pulses when `hs_rise` arrives with the previous `h_idx != H_TOTAL-1`.
    - Also pulses exactly once when `h_idx` reaches `H_TOTAL` without an `hs_rise` (timeout).
  - `err_frame`:
    - Pulses when `vs_rise` arrives with the previous `v_idx != V_TOTAL-1`.
    - Also pulses once when `v_idx` reaches `V_TOTAL` (missing vsync).
  - When line and frame errors occur in the same cycle, both pulse.
- **Stage 2: output register.**
  - `pix_valid = locked && H_ACT_START <= h_idx < H_ACT_START+H_DISP && V_ACT_START <= v_idx < V_ACT_START+V_DISP`.
  - `pix_x = h_idx - H_ACT_START` and `pix_y = v_idx - V_ACT_START`, each truncated to 10 bits.
  - `pix_rgb = rgb_q`.
  - When `pix_valid` is 0, `pix_x`, `pix_y` and `pix_rgb` are forced to 0.

## Timing
- Latency is 2 clocks from input pins to `pix_*`. `frame_start` and the `err_*` pulses are registered with the same 2-clock latency, so they stay aligned with the pixel stream.
- Reset values:
  - All outputs are 0.
  - The FSM is in `UNLOCK`.
  - `h_idx` and `v_idx` are 1023, so they are saturated.
  - All sync history registers are 0.
- Reset mid-frame: outputs drop to 0 on the next clock and the first frame after release is never valid. Earliest lock is the second `vs_rise` after release.
- Lock effect on output:
  - `pix_valid` can first assert on the first active pixel after entering `LOCKED`.
  - Losing lock deasserts `pix_valid` on the cycle after the error pulse.
- Sync widths are not checked; only the rising-edge spacing is checked.

## Structure
- Shared package `vga_pkg` holds:
  - the timing constants, shared with the output driver;
  - the lock FSM state typedef (`UNLOCK`, `TRACK`, `LOCKED`).
- One natural sub-module is `sync_edge_det` (register, history, rise pulse). It is instantiated twice, for hs and vs.
- Everything else is flat, at roughly 150–250 lines.

## Test plan
- **Nominal stream:** bench generator (800x525, hs high for clocks 0..94, vs high for line 0) for 3 frames.
  - `locked` rises at the 2nd `frame_start`.
  - In frame 3, exactly 307200 `pix_valid` cycles.
  - The first one is (0,0), at sample index 144 of line 35.
  - The last one is (639,479).
  - `pix_rgb` equals the driven pattern delayed 2 clocks.
- **Short line:** one 799-clock line while `LOCKED`.
  - One `err_line` pulse.
  - `locked` drops on the next clock.
  - Relocks after 2 clean vs edges.
- **Missing vsync:** vs suppressed for one frame.
  - `err_frame` pulses once when `v_idx` reaches 525.
  - `locked` goes to 0.
  - No `pix_valid` until relock.
- **Reset mid-frame:** `rst` held for 10 clocks at line 200.
  - All outputs are 0 during reset and afterwards.
  - No `pix_valid` before the 2nd post-reset `vs_rise` and the following active region.
- **Coincident edges:** hs and vs rise on the same clock.
  - `v_idx` = 0 (vs_rise priority).
  - No `err_line`.
  - `frame_start` occurs exactly once.
- **Stalled hsync:** hs held low for 2000 clocks while `LOCKED`.
  - Exactly one `err_line` pulse, at the 800th clock after the last rise.
  - `h_idx` saturates with no wrap.
